// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI byte master.
package spi_pkg;

  localparam int SPI_DATA_W      = 8;  // bits per transfer
  localparam int SPI_CLK_DIV_DEF = 4;  // sys_clk cycles per SCLK half-period

  // Transfer sequencing: CS setup, 8 SCLK periods, CS hold, back to idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider and SCLK generator. Produces a tick at the end of every
// CLK_DIV-cycle phase, and rise/fall strobes in the cycle before SCLK changes.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,         // counting enabled (transfer in progress)
  input  logic toggle_en,  // SCLK toggles at the end of the current phase
  output logic tick,       // last cycle of the current phase
  output logic sclk,
  output logic rise,       // SCLK goes high after this cycle
  output logic fall        // SCLK goes low after this cycle
);

  logic [7:0] cnt;

  assign tick = en && (cnt == 8'(CLK_DIV - 1));
  assign rise = tick && toggle_en && !sclk;
  assign fall = tick && toggle_en && sclk;

  // Phase counter: wraps at CLK_DIV-1, held at zero while idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= 8'd0;
    end else if (!en || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // SCLK register: idle low, toggles at phase boundaries when enabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk <= 1'b0;
    end else if (!en) begin
      sclk <= 1'b0;
    end else if (tick && toggle_en) begin
      sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: one byte out on MOSI (MSB first) while one byte is
// captured from MISO. Optional SPI_LOOPBACK_EN samples internal MOSI instead
// of the MISO pin.
//
// Handshake: a byte is taken in the cycle where tx_valid && tx_ready are both
// high; tx_ready is high only while idle, and tx_valid is ignored otherwise.
// The result appears as a single-cycle rx_valid pulse with rx_data, and
// rx_data holds until the next completed transfer.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              CS,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  // SHIFT covers 2*DATA_W half-period phases; the last one is SCLK-low.
  localparam int              PH_W         = $clog2(2 * DATA_W);
  localparam logic [PH_W-1:0] PH_LAST      = PH_W'(2 * DATA_W - 1);
  localparam logic [PH_W-1:0] PH_LAST_FALL = PH_W'(2 * DATA_W - 2);

  spi_state_e        state, state_nxt;
  logic              rdy_en;
  logic [PH_W-1:0]   ph;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              accept;
  logic              div_en, toggle_en;
  logic              tick, rise, fall;
  logic              sample_bit;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign sample_bit  = tx_sh[DATA_W-1];
`else
  assign sample_bit  = MISO;
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (div_en),
    .toggle_en (toggle_en),
    .tick      (tick),
    .sclk      (SCLK),
    .rise      (rise),
    .fall      (fall)
  );

  assign accept = tx_valid && tx_ready;
  assign MOSI   = busy && tx_sh[DATA_W-1];

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    busy      = 1'b1;
    CS        = 1'b0;
    div_en    = 1'b1;
    toggle_en = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_ready = rdy_en;
        busy     = 1'b0;
        CS       = 1'b1;
        div_en   = 1'b0;
        if (tx_valid && rdy_en) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        toggle_en = 1'b1;
        if (tick) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        toggle_en = (ph != PH_LAST);
        if (tick && ph == PH_LAST) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Keeps tx_ready low until the first clock edge after reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rdy_en <= 1'b0;
    else            rdy_en <= 1'b1;
  end

  // Phase index within SHIFT and the two shift registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ph    <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
    end else begin
      if (state == ST_SETUP)               ph <= '0;
      else if (state == ST_SHIFT && tick)  ph <= ph + 1'b1;

      // The final falling edge does not advance MOSI.
      if (accept)                          tx_sh <= tx_data;
      else if (fall && ph != PH_LAST_FALL) tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};

      if (accept)                          rx_sh <= '0;
      else if (rise)                       rx_sh <= {rx_sh[DATA_W-2:0], sample_bit};
    end
  end

  // Result register and completion pulse, issued as CS returns high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == ST_HOLD && tick) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 SHALL have parameter: CLK_DIV, 4, sys_clk cycles per SCLK half-period (legal 1..255).
REQ-002 SHALL have parameter: DATA_W, 8, bits per transfer (fixed 8 this revision).
REQ-003 SHALL have port: sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port: sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: tx_data  input  8  byte to send (e.g. upstream counter value).
REQ-006 SHALL have port: tx_valid  input  1  tx_data valid.
REQ-007 SHALL have port: tx_ready  output  1  block can accept a byte.
REQ-008 SHALL have port: rx_data  output  8  byte captured from MISO.
REQ-009 SHALL have port: rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-010 SHALL have port: busy  output  1  transfer in progress (CS low).
REQ-011 SHALL have port: CS  output  1  chip select, active low.
REQ-012 SHALL have port: SCLK  output  1  serial clock, idle low.
REQ-013 SHALL have port: MOSI  output  1  serial data out, MSB first.
REQ-014 SHALL have port: MISO  input  1  serial data in.

Function
REQ-015 SHALL implement SPI mode 0: MOSI changes on SCLK falling edge (or at CS fall for bit 7); MISO sampled on SCLK rising edge.
REQ-016 SHALL accept a byte in cycle T0 when tx_valid && tx_ready; tx_data registered at T0; later tx_data changes ignored.
REQ-017 SHALL use FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE; tx_ready=1 only in IDLE.
REQ-018 SHALL in T0+1 enter SETUP: CS=0, MOSI=bit7, busy=1; SETUP lasts CLK_DIV cycles.
REQ-019 SHALL in SHIFT generate 8 SCLK periods, each CLK_DIV cycles high then CLK_DIV low; bit shifts out on each falling edge except the 8th.
REQ-020 SHALL in HOLD keep CS=0, SCLK=0 for CLK_DIV cycles.
REQ-021 SHALL hold CS low for exactly 18*CLK_DIV cycles; in the cycle CS returns high: rx_valid=1 (one cycle), rx_data updated, busy=0, tx_ready=1.
REQ-022 SHALL, with tx_valid held high, start the next transfer immediately: CS high for exactly 1 cycle between transfers.
REQ-023 SHALL ignore tx_valid while busy; no queuing.
REQ-024 SHALL shift rx bits in MSB first; rx_data holds its value until the next completion.
REQ-025 SHALL use an 8-bit divider counter wrapping at CLK_DIV-1; CLK_DIV=1 gives SCLK = sys_clk/2.

Reset
REQ-026 SHALL on sys_rst_n=0 immediately force CS=1, SCLK=0, MOSI=0, tx_ready=0, rx_valid=0, busy=0, rx_data=8'h00, FSM=IDLE.
REQ-027 SHALL assert tx_ready in the first sys_clk cycle after reset release.
REQ-028 SHALL abort a transfer on reset mid-operation with no rx_valid and no partial rx_data update.

Configuration
REQ-029 SHALL with SPI_LOOPBACK_EN defined sample the internal MOSI value instead of MISO; MISO ignored.
REQ-030 SHALL without SPI_LOOPBACK_EN sample the MISO port; no loopback logic present.

Structure
REQ-031 SHALL place the FSM state enum, DATA_W and default CLK_DIV constants in shared package spi_pkg.
REQ-032 SHALL implement the divider/edge-strobe generator as sub-module spi_clk_div (outputs rise/fall strobes).

Verification
REQ-033 SHALL cover: CLK_DIV=2, tx 8'hA5, slave model returns 8'h3C -> MOSI 1,0,1,0,0,1,0,1 at SCLK rises; CS low 36 cycles; rx_data=8'h3C with one rx_valid pulse.
REQ-034 SHALL cover: tx_valid held high with 8'h01 then 8'h02 -> two transfers, CS high exactly 1 cycle between, rx_valid pulses twice.
REQ-035 SHALL cover: sys_rst_n low after 3rd SCLK rise -> CS=1 and SCLK=0 without waiting for a clock edge; no rx_valid; tx_ready=1 one cycle after release.
REQ-036 SHALL cover: CLK_DIV=1, tx 8'hFF, MISO=0 -> CS low 18 cycles, 8 SCLK pulses, rx_data=8'h00.
REQ-037 SHALL cover: SPI_LOOPBACK_EN defined, MISO=1, tx 8'h5A -> rx_data=8'h5A.
REQ-038 SHALL cover: tx_valid pulsed mid-transfer with 8'h77 -> ignored; no extra transfer; busy stays 1 until completion.
